reg_shift_sequencer: RTL and testbench

Multi-cycle controller that sequences register-specified shifts (ARM "Rm, <shift> Rs" operand form) for the execute stage. The immediate operand path handles only immediate rotates and immediate shift amounts. This block instead borrows a register-file read port to fetch Rs, stalls the pipeline while it does, and computes the shifted Val2 and the shifter carry-out with full ARM semantics for amounts 0–255. It sits beside the immediate Val2 path in EX; the EX operand mux selects its `val2` when `done` is high.

---
 rtl/reg_shift_sequencer.sv | 139 +++++++++++++
 tb/tb_reg_shift_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_shift_sequencer.sv
// Register-specified shift sequencer for EX: fetches Rs through a borrowed
// register-file read port, then produces Val2 and the shifter carry-out.
module reg_shift_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        flush,
  input  logic [1:0]  shift_type,
  input  logic [3:0]  rs_num,
  input  logic [31:0] val_rm,
  input  logic        carry_in,
  output logic        rs_rd_req,
  output logic [3:0]  rs_addr,
  input  logic [31:0] rs_rd_data,
  output logic        stall,
  output logic        done,
  output logic [31:0] val2,
  output logic        carry_out
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    SHIFT,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  type_q;
  logic [3:0]  rs_q;
  logic [31:0] rm_q;
  logic        c_q;
  logic [7:0]  amt_q;
  logic [31:0] val2_q, val2_d;
  logic        carry_q, carry_d;

  logic        cap;
  logic [4:0]  sh;
  logic [4:0]  ish;
  logic        big;
  logic        is32;
  logic [63:0] rot_w;

  assign cap = (state_q == IDLE) & start & ~flush;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (cap) state_d = READ;
      READ:  state_d = SHIFT;
      SHIFT: state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      type_q  <= 2'b00;
      rs_q    <= 4'd0;
      rm_q    <= 32'd0;
      c_q     <= 1'b0;
      amt_q   <= 8'd0;
      val2_q  <= 32'd0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (cap) begin
        type_q <= shift_type;
        rs_q   <= rs_num;
        rm_q   <= val_rm;
        c_q    <= carry_in;
      end
      if (state_q == READ) amt_q <= rs_rd_data[7:0];
      if (state_q == SHIFT && !flush) begin
        val2_q  <= val2_d;
        carry_q <= carry_d;
      end
    end
  end

  // amounts 32..255 all have a nonzero bit in [7:5]
  assign sh    = amt_q[4:0];
  assign ish   = 5'd0 - sh;
  assign big   = |amt_q[7:5];
  assign is32  = (amt_q == 8'd32);
  assign rot_w = {rm_q, rm_q} >> sh;

  always_comb begin
    val2_d  = rm_q;
    carry_d = c_q;
    if (amt_q != 8'd0) begin
      unique case (type_q)
        2'b00: begin
          if (big) begin
            val2_d  = 32'd0;
            carry_d = is32 & rm_q[0];
          end else begin
            val2_d  = rm_q << sh;
            carry_d = rm_q[ish];
          end
        end
        2'b01: begin
          if (big) begin
            val2_d  = 32'd0;
            carry_d = is32 & rm_q[31];
          end else begin
            val2_d  = rm_q >> sh;
            carry_d = rm_q[sh - 5'd1];
          end
        end
        2'b10: begin
          if (big) begin
            val2_d  = {32{rm_q[31]}};
            carry_d = rm_q[31];
          end else begin
            val2_d  = $signed(rm_q) >>> sh;
            carry_d = rm_q[sh - 5'd1];
          end
        end
        default: begin
          // last bit rotated out always lands in bit 31
          val2_d  = rot_w[31:0];
          carry_d = rot_w[31];
        end
      endcase
    end
  end

  assign rs_rd_req = (state_q == READ);
  assign rs_addr   = rs_q;
  assign done      = (state_q == DONE);
  assign val2      = val2_q;
  assign carry_out = carry_q;
  assign stall     = rst_n & (cap | (state_q == READ) | (state_q == SHIFT));

endmodule

// File: tb/tb_reg_shift_sequencer.sv
// Scoreboard bench for reg_shift_sequencer: a bitwise iterative shift model
// predicts each result; a done monitor pops and compares.
module tb_reg_shift_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        flush;
  logic [1:0]  shift_type;
  logic [3:0]  rs_num;
  logic [31:0] val_rm;
  logic        carry_in;
  logic        rs_rd_req;
  logic [3:0]  rs_addr;
  logic [31:0] rs_rd_data;
  logic        stall;
  logic        done;
  logic [31:0] val2;
  logic        carry_out;

  logic [31:0] rf [16];
  logic [32:0] exp_q [$];
  logic [32:0] mon_e;
  logic [32:0] last_res;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_done_cyc = 0;
  int prev_done_cyc = 0;

  always #5 clk = ~clk;

  assign rs_rd_data = rf[rs_addr];

  reg_shift_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .flush     (flush),
    .shift_type(shift_type),
    .rs_num    (rs_num),
    .val_rm    (val_rm),
    .carry_in  (carry_in),
    .rs_rd_req (rs_rd_req),
    .rs_addr   (rs_addr),
    .rs_rd_data(rs_rd_data),
    .stall     (stall),
    .done      (done),
    .val2      (val2),
    .carry_out (carry_out)
  );

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // one bit per iteration, carry = last bit shifted out
  function automatic logic [32:0] model(logic [1:0] t, logic [31:0] m,
                                        logic c, logic [7:0] n);
    logic [31:0] r;
    logic        co;
    r  = m;
    co = c;
    for (int i = 0; i < int'(n); i++) begin
      case (t)
        2'b00: begin co = r[31]; r = r << 1; end
        2'b01: begin co = r[0]; r = r >> 1; end
        2'b10: begin co = r[0]; r = {r[31], r[31:1]}; end
        default: begin co = r[0]; r = {r[0], r[31:1]}; end
      endcase
    end
    return {co, r};
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      prev_done_cyc = last_done_cyc;
      last_done_cyc = cyc;
      if (exp_q.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        last_res = mon_e;
        chk("val2", val2, mon_e[31:0]);
        chk("carry", carry_out, mon_e[32]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(logic [1:0] t, logic [3:0] rs, logic [31:0] rsv,
                       logic [31:0] m, logic c, bit push);
    rf[rs]     = rsv;
    shift_type = t;
    rs_num     = rs;
    val_rm     = m;
    carry_in   = c;
    start      = 1'b1;
    if (push) exp_q.push_back(model(t, m, c, rsv[7:0]));
    step();
    start = 1'b0;
  endtask

  task automatic run_op(logic [1:0] t, logic [3:0] rs, logic [31:0] rsv,
                        logic [31:0] m, logic c);
    issue(t, rs, rsv, m, c, 1'b1);
    step();
    step();
    chk("done_lat", done, 1);
    step();
  endtask

  initial begin
    int base;
    int amts [7] = '{0, 1, 31, 32, 33, 40, 255};
    logic [7:0] a;
    rst_n = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    shift_type = 2'b00;
    rs_num = 4'd0;
    val_rm = 32'd0;
    carry_in = 1'b0;
    for (int i = 0; i < 16; i++) rf[i] = 32'd0;
    last_res = 33'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_val2", val2, 0);
    chk("rst_carry", carry_out, 0);
    chk("rst_done", done, 0);
    chk("rst_req", rs_rd_req, 0);
    chk("rst_addr", rs_addr, 0);
    chk("rst_stall", stall, 0);
    rst_n = 1'b1;
    step();

    // LSL by 1 with detailed cycle checks
    rf[3] = 32'd1;
    shift_type = 2'b00;
    rs_num = 4'd3;
    val_rm = 32'h8000_0001;
    carry_in = 1'b0;
    start = 1'b1;
    exp_q.push_back({1'b1, 32'h0000_0002});
    #1 chk("stall_c0", stall, 1);
    step();
    start = 1'b0;
    #1;
    chk("stall_c1", stall, 1);
    chk("req_c1", rs_rd_req, 1);
    chk("addr_c1", rs_addr, 3);
    step();
    chk("stall_c2", stall, 1);
    chk("req_c2", rs_rd_req, 0);
    step();
    chk("done_c3", done, 1);
    chk("stall_c3", stall, 0);
    chk("req_c3", rs_rd_req, 0);
    step();
    chk("done_c4", done, 0);

    // zero amount with junk above bit 7
    for (int t = 0; t < 4; t++)
      run_op(2'(t), 4'd5, 32'h0000_0100, 32'hA5A5_0F0F, 1'b1);
    run_op(2'b01, 4'd6, 32'd32, 32'h8000_0000, 1'b0);
    run_op(2'b00, 4'd7, 32'd33, 32'hFFFF_FFFF, 1'b1);
    run_op(2'b10, 4'd8, 32'd40, 32'h8000_0000, 1'b0);
    run_op(2'b11, 4'd9, 32'd1, 32'h0000_0001, 1'b0);
    run_op(2'b11, 4'd10, 32'd32, 32'h8000_0000, 1'b0);

    // flush in READ
    base = done_cnt;
    issue(2'b00, 4'd11, 32'd4, 32'h1234_5678, 1'b0, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_stall", stall, 0);
    chk("fl_req", rs_rd_req, 0);
    chk("fl_done", done, 0);
    chk("fl_val2", val2, last_res[31:0]);
    repeat (4) step();
    chk("fl_nodone", done_cnt, base);

    // flush together with start in IDLE
    rf[12] = 32'd2;
    shift_type = 2'b01;
    rs_num = 4'd12;
    val_rm = 32'hFFFF_0000;
    start = 1'b1;
    flush = 1'b1;
    #1 chk("fs_stall0", stall, 0);
    step();
    start = 1'b0;
    flush = 1'b0;
    chk("fs_req", rs_rd_req, 0);
    chk("fs_stall1", stall, 0);
    repeat (4) step();
    chk("fs_nodone", done_cnt, base);

    // async reset during SHIFT
    issue(2'b01, 4'd13, 32'd3, 32'hF000_000F, 1'b1, 1'b0);
    step();
    chk("rs_inshift", stall, 1);
    start = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("ar_val2", val2, 0);
    chk("ar_carry", carry_out, 0);
    chk("ar_done", done, 0);
    chk("ar_req", rs_rd_req, 0);
    chk("ar_stall", stall, 0);
    start = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (4) step();
    chk("ar_nodone", done_cnt, base);

    // back-to-back, with start toggled during READ/SHIFT
    issue(2'b10, 4'd1, 32'd4, 32'h8765_4321, 1'b0, 1'b1);
    start = 1'b1;
    shift_type = 2'b11;
    val_rm = 32'hDEAD_BEEF;
    carry_in = 1'b1;
    step();
    step();
    start = 1'b0;
    chk("bb_done1", done, 1);
    step();
    issue(2'b01, 4'd2, 32'h0000_1F05, 32'h8000_0010, 1'b1, 1'b1);
    step();
    step();
    chk("bb_done2", done, 1);
    step();
    chk("bb_count", done_cnt, base + 2);
    chk("bb_gap", last_done_cyc - prev_done_cyc, 4);

    // random ops over boundary amounts
    for (int k = 0; k < 24; k++) begin
      if (k % 3 == 2) a = 8'($urandom_range(0, 255));
      else a = 8'(amts[$urandom_range(0, 6)]);
      run_op(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
             ($urandom() & 32'hFFFF_FF00) | 32'(a),
             $urandom(), 1'($urandom_range(0, 1)));
    end

    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
